ccip_c0_rd_arbiter: RTL and testbench

Round-robin arbiter that shares the CCI-P channel-0 read-request port among NUM_REQ internal requesters inside the AFU, below the interface register stage and above the test engines. It tags each issued request's mdata with the requester ID and routes channel-0 read responses back to the originating requester. It tracks outstanding reads per requester, enforces a per-requester cap, and honours c0TxAlmFull.

---
 rtl/ccip_c0_rd_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_ccip_c0_rd_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_c0_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ccip_c0_rd_arbiter
//  Description : Round-robin arbiter sharing the CCI-P channel-0 read-request
//                port among NUM_REQ requesters. Tags mdata[15:12] with the
//                requester ID, routes read responses back by that ID, tracks
//                and caps per-requester outstanding reads, honours c0TxAlmFull.
//  Revision    : 1.0 - initial release
// ============================================================================
module ccip_c0_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 64
) (
    input  logic                    pClk,
    input  logic                    pck_cp2af_softReset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*42-1:0]   req_addr,
    input  logic [NUM_REQ*12-1:0]   req_mdata,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    c0TxAlmFull,
    output logic                    c0tx_valid,
    output logic [41:0]             c0tx_addr,
    output logic [15:0]             c0tx_mdata,
    input  logic                    c0rx_rspValid,
    input  logic [15:0]             c0rx_mdata,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [11:0]             rsp_mdata,
    output logic [NUM_REQ*7-1:0]    outst_cnt,
    output logic                    err,
    output logic                    idle
);

    localparam int C_ID_W   = 4;
    localparam int C_CNT_W  = 7;
    localparam int C_ADDR_W = 42;
    localparam int C_TAG_W  = 12;
    localparam int C_SCAN_W = C_ID_W + 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [C_ID_W-1:0]      rr_ptr_q,     rr_ptr_d;
    logic                   c0tx_valid_q, c0tx_valid_d;
    logic [C_ADDR_W-1:0]    c0tx_addr_q,  c0tx_addr_d;
    logic [15:0]            c0tx_mdata_q, c0tx_mdata_d;
    logic [NUM_REQ-1:0]     rsp_valid_q,  rsp_valid_d;
    logic [C_TAG_W-1:0]     rsp_mdata_q,  rsp_mdata_d;
    logic [C_CNT_W-1:0]     cnt_q [NUM_REQ];
    logic [C_CNT_W-1:0]     cnt_d [NUM_REQ];
    logic                   err_q,        err_d;
    logic                   idle_q,       idle_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0]     eligible;
    logic [15:0]            elig_ext;     // padded so a 4-bit scan index is always in range
    logic [C_SCAN_W-1:0]    scan_idx;
    logic                   gnt_found;
    logic [C_ID_W-1:0]      gnt_id;
    logic                   gnt_fire;
    logic [C_ID_W-1:0]      rsp_id;
    logic                   rsp_id_ok;
    logic [NUM_REQ-1:0]     cnt_inc;
    logic [NUM_REQ-1:0]     rsp_hit;
    logic [NUM_REQ-1:0]     cnt_dec;
    logic                   all_zero;

    assign rsp_id    = c0rx_mdata[15:12];
    assign rsp_id_ok = (C_SCAN_W'(rsp_id) < C_SCAN_W'(NUM_REQ));
    assign elig_ext  = 16'(eligible);

    // Per-requester eligibility and counter-event decode.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign eligible[i] = req_valid[i] && (cnt_q[i] < C_CNT_W'(MAX_OUTST));
        assign cnt_inc[i]  = gnt_fire && (gnt_id == C_ID_W'(i));
        assign rsp_hit[i]  = c0rx_rspValid && (rsp_id == C_ID_W'(i));
        // A response to an empty counter is an error and must not wrap it.
        assign cnt_dec[i]  = rsp_hit[i] && (cnt_q[i] != '0);
        assign outst_cnt[i*C_CNT_W +: C_CNT_W] = cnt_q[i];
    end

    // Round-robin scan: first eligible requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + C_SCAN_W'(k);
            if (scan_idx >= C_SCAN_W'(NUM_REQ)) begin
                scan_idx = scan_idx - C_SCAN_W'(NUM_REQ);
            end
            if (!gnt_found && elig_ext[scan_idx[C_ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = scan_idx[C_ID_W-1:0];
            end
        end
    end

    // Grants are suppressed while the CCI-P channel-0 TX queue is almost full.
    assign gnt_fire = gnt_found && !c0TxAlmFull;

    // One-hot grant; held low while reset is asserted regardless of requests.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = pck_cp2af_softReset_n && cnt_inc[i];
        end
    end

    // Pointer moves one past the granted requester; holds without a grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_fire) begin
            rr_ptr_d = (gnt_id == C_ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Request issue: capture the winner's address and ID-tagged mdata.
    always_comb begin
        c0tx_valid_d = gnt_fire;
        c0tx_addr_d  = c0tx_addr_q;
        c0tx_mdata_d = c0tx_mdata_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_inc[i]) begin
                c0tx_addr_d  = req_addr[i*C_ADDR_W +: C_ADDR_W];
                c0tx_mdata_d = {gnt_id, req_mdata[i*C_TAG_W +: C_TAG_W]};
            end
        end
    end

    // Response routing, error detection and outstanding-count update.
    always_comb begin
        rsp_valid_d = '0;
        rsp_mdata_d = rsp_mdata_q;
        err_d       = err_q;
        if (c0rx_rspValid) begin
            if (rsp_id_ok) begin
                rsp_mdata_d = c0rx_mdata[C_TAG_W-1:0];
            end else begin
                // Unknown requester: drop the response entirely.
                err_d = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = rsp_hit[i];
            if (rsp_hit[i] && (cnt_q[i] == '0)) begin
                err_d = 1'b1;
            end
            case ({cnt_inc[i], cnt_dec[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Idle is computed from next-state so it lines up with the registered view.
    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_d[i] != '0) begin
                all_zero = 1'b0;
            end
        end
        idle_d = all_zero && !c0tx_valid_d;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            rr_ptr_q     <= '0;
            c0tx_valid_q <= 1'b0;
            c0tx_addr_q  <= '0;
            c0tx_mdata_q <= '0;
            rsp_valid_q  <= '0;
            rsp_mdata_q  <= '0;
            err_q        <= 1'b0;
            idle_q       <= 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            c0tx_valid_q <= c0tx_valid_d;
            c0tx_addr_q  <= c0tx_addr_d;
            c0tx_mdata_q <= c0tx_mdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_mdata_q  <= rsp_mdata_d;
            err_q        <= err_d;
            idle_q       <= idle_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign c0tx_valid = c0tx_valid_q;
    assign c0tx_addr  = c0tx_addr_q;
    assign c0tx_mdata = c0tx_mdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_mdata  = rsp_mdata_q;
    assign err        = err_q;
    assign idle       = idle_q;

endmodule
`default_nettype wire

// File: tb/tb_ccip_c0_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccip_c0_rd_arbiter
//  Description : Self-checking bench for ccip_c0_rd_arbiter: directed
//                scenarios plus randomized traffic against a transaction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccip_c0_rd_arbiter;

    localparam int NR = 4;
    localparam int MX = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NR-1:0]        req_valid;
    logic [NR*42-1:0]     req_addr;
    logic [NR*12-1:0]     req_mdata;
    logic [NR-1:0]        req_ready;
    logic                 c0TxAlmFull;
    logic                 c0tx_valid;
    logic [41:0]          c0tx_addr;
    logic [15:0]          c0tx_mdata;
    logic                 c0rx_rspValid;
    logic [15:0]          c0rx_mdata;
    logic [NR-1:0]        rsp_valid;
    logic [11:0]          rsp_mdata;
    logic [NR*7-1:0]      outst_cnt;
    logic                 err;
    logic                 idle;

    always #5 clk = ~clk;

    ccip_c0_rd_arbiter #(.NUM_REQ(NR), .MAX_OUTST(MX)) u_dut (
        .pClk                  (clk),
        .pck_cp2af_softReset_n (rst_n),
        .req_valid             (req_valid),
        .req_addr              (req_addr),
        .req_mdata             (req_mdata),
        .req_ready             (req_ready),
        .c0TxAlmFull           (c0TxAlmFull),
        .c0tx_valid            (c0tx_valid),
        .c0tx_addr             (c0tx_addr),
        .c0tx_mdata            (c0tx_mdata),
        .c0rx_rspValid         (c0rx_rspValid),
        .c0rx_mdata            (c0rx_mdata),
        .rsp_valid             (rsp_valid),
        .rsp_mdata             (rsp_mdata),
        .outst_cnt             (outst_cnt),
        .err                   (err),
        .idle                  (idle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (transaction level)
    int             m_ptr;
    int             m_cnt [NR];
    logic           m_err;
    logic           m_tx_valid;
    logic [41:0]    m_tx_addr;
    logic [15:0]    m_tx_mdata;
    logic [NR-1:0]  m_rsp_valid;
    logic [11:0]    m_rsp_mdata;
    logic           m_idle;
    logic [15:0]    pend [$];     // mdata of requests still awaiting a response
    logic [NR-1:0]  obs_ready;
    logic [NR*42-1:0] d_addr;
    logic [NR*12-1:0] d_tag;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_err = 1'b0; m_tx_valid = 1'b0; m_tx_addr = '0; m_tx_mdata = '0;
        m_rsp_valid = '0; m_rsp_mdata = '0; m_idle = 1'b1;
    endtask

    function automatic logic [NR*7-1:0] m_cnt_vec();
        logic [NR*7-1:0] v;
        for (int i = 0; i < NR; i++) v[i*7 +: 7] = 7'(m_cnt[i]);
        return v;
    endfunction

    task automatic check_regs();
        check_eq("c0tx_valid", 64'(c0tx_valid), 64'(m_tx_valid));
        check_eq("c0tx_addr",  64'(c0tx_addr),  64'(m_tx_addr));
        check_eq("c0tx_mdata", 64'(c0tx_mdata), 64'(m_tx_mdata));
        check_eq("rsp_valid",  64'(rsp_valid),  64'(m_rsp_valid));
        check_eq("rsp_mdata",  64'(rsp_mdata),  64'(m_rsp_mdata));
        check_eq("outst_cnt",  64'(outst_cnt),  64'(m_cnt_vec()));
        check_eq("err",        64'(err),        64'(m_err));
        check_eq("idle",       64'(idle),       64'(m_idle));
    endtask

    // One clock cycle: drive, check the combinational grant, advance model, check registers.
    task automatic step(input logic [NR-1:0] v, input logic [NR*42-1:0] a, input logic [NR*12-1:0] t,
                        input logic af, input logic rv, input logic [15:0] rm);
        int  g;
        int  id;
        int  cand;
        bit  zero;
        @(negedge clk);
        req_valid = v; req_addr = a; req_mdata = t;
        c0TxAlmFull = af; c0rx_rspValid = rv; c0rx_mdata = rm;
        #1;
        g = -1;
        if (!af) begin
            for (int k = 0; k < NR; k++) begin
                cand = (m_ptr + k) % NR;
                if (g < 0 && v[cand] && m_cnt[cand] < MX) g = cand;
            end
        end
        obs_ready = req_ready;
        check_eq("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);

        m_rsp_valid = '0;
        if (rv) begin
            id = int'(rm[15:12]);
            if (id >= NR) begin
                m_err = 1'b1;
            end else begin
                m_rsp_valid[id] = 1'b1;
                m_rsp_mdata     = rm[11:0];
                if (m_cnt[id] == 0) m_err = 1'b1;
                else                m_cnt[id]--;
            end
        end
        if (g >= 0) begin
            m_cnt[g]++;
            m_tx_valid = 1'b1;
            m_tx_addr  = a[42*g +: 42];
            m_tx_mdata = {4'(g), t[12*g +: 12]};
            m_ptr      = (g + 1) % NR;
            pend.push_back(m_tx_mdata);
        end else begin
            m_tx_valid = 1'b0;
        end
        zero = 1'b1;
        for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) zero = 1'b0;
        m_idle = zero && !m_tx_valid;

        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic drain();
        logic [15:0] rm;
        while (pend.size() > 0) begin
            rm = pend.pop_front();
            step('0, d_addr, d_tag, 1'b0, 1'b1, rm);
        end
    endtask

    function automatic logic [15:0] take_pend(input int id);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int j = 0; j < pend.size(); j++) begin
            if (int'(pend[j][15:12]) == id) begin
                r = pend[j];
                pend.delete(j);
                break;
            end
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR*42-1:0] ra;
        logic [NR*12-1:0] rt;
        logic [15:0]      rm;
        logic             rv;
        int               j;

        for (int i = 0; i < NR; i++) begin
            d_addr[42*i +: 42] = 42'(64'h1000 * (i + 1));
            d_tag[12*i +: 12]  = 12'(12'h100 + i);
        end

        // Reset with requests pending: no grant may leak out.
        rst_n = 1'b0;
        req_valid = '1; req_addr = d_addr; req_mdata = d_tag;
        c0TxAlmFull = 1'b0; c0rx_rspValid = 1'b0; c0rx_mdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        check_regs();
        @(negedge clk);
        rst_n = 1'b1; req_valid = '0;

        // Persistent load: strict 0,1,2,3,0,1,2,3 rotation.
        for (int k = 0; k < 8; k++) begin
            step('1, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
            check_eq("rr_seq_id",  64'(c0tx_mdata[15:12]), 64'(k % NR));
            check_eq("rr_seq_vld", 64'(c0tx_valid), 64'd1);
        end
        step('1, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        check_eq("cap_all_ready", 64'(obs_ready), 64'd0);
        drain();

        // Single request and its response.
        d_addr[42*2 +: 42] = 42'h123;
        d_tag[12*2 +: 12]  = 12'hABC;
        step(4'b0100, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        check_eq("single_addr",  64'(c0tx_addr),  64'h123);
        check_eq("single_mdata", 64'(c0tx_mdata), 64'h2ABC);
        check_eq("single_cnt",   64'(outst_cnt[14 +: 7]), 64'd1);
        rm = take_pend(2);
        step('0, d_addr, d_tag, 1'b0, 1'b1, rm);
        check_eq("single_rspv", 64'(rsp_valid), 64'b0100);
        check_eq("single_rspm", 64'(rsp_mdata), 64'hABC);
        check_eq("single_cnt0", 64'(outst_cnt[14 +: 7]), 64'd0);
        check_eq("single_idle", 64'(idle), 64'd1);

        // Cap on requester 1.
        step(4'b0010, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        step(4'b0010, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        step(4'b0010, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        check_eq("cap_ready_lo", 64'(obs_ready[1]), 64'd0);
        rm = take_pend(1);
        step(4'b0010, d_addr, d_tag, 1'b0, 1'b1, rm);
        check_eq("cap_ready_same", 64'(obs_ready[1]), 64'd0);
        rm = take_pend(1);
        step(4'b0010, d_addr, d_tag, 1'b0, 1'b1, rm);
        check_eq("cap_ready_back", 64'(obs_ready[1]), 64'd1);
        check_eq("cap_cnt_hold",   64'(outst_cnt[7 +: 7]), 64'd1);
        drain();

        // Almost-full stall; arbitration resumes at the held pointer.
        step('1, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        step('1, d_addr, d_tag, 1'b1, 1'b0, 16'h0);
        check_eq("af_ready", 64'(obs_ready), 64'd0);
        step('1, d_addr, d_tag, 1'b1, 1'b0, 16'h0);
        check_eq("af_no_issue", 64'(c0tx_valid), 64'd0);
        step('1, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        check_eq("af_resume", 64'(obs_ready), 64'b1000);
        drain();

        // Randomized traffic with legitimate responses only.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                ra[42*i +: 42] = 42'({$urandom(), $urandom()});
                rt[12*i +: 12] = 12'($urandom());
            end
            rv = 1'b0;
            rm = 16'($urandom());
            if (pend.size() > 0 && $urandom_range(0, 99) < 45) begin
                j  = int'($urandom_range(0, pend.size() - 1));
                rm = pend[j];
                pend.delete(j);
                rv = 1'b1;
            end
            step(NR'($urandom()), ra, rt, ($urandom_range(0, 99) < 20), rv, rm);
        end
        drain();

        // Protocol errors.
        check_eq("err_pre", 64'(err), 64'd0);
        step('0, d_addr, d_tag, 1'b0, 1'b1, 16'h7000);
        check_eq("badid_rspv", 64'(rsp_valid), 64'd0);
        check_eq("badid_err",  64'(err), 64'd1);
        step('0, d_addr, d_tag, 1'b0, 1'b1, 16'h1055);
        check_eq("zero_rspv", 64'(rsp_valid), 64'b0010);
        check_eq("zero_cnt",  64'(outst_cnt[7 +: 7]), 64'd0);

        // Asynchronous reset in the middle of a burst.
        step('1, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        step('1, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        req_valid = '1; c0rx_rspValid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid_rst_ready", 64'(req_ready), 64'd0);
        check_regs();
        @(negedge clk);
        rst_n = 1'b1; req_valid = '0;
        rm = pend.pop_front();
        step('0, d_addr, d_tag, 1'b0, 1'b1, rm);
        check_eq("stale_err", 64'(err), 64'd1);
        pend.delete();
        step('1, d_addr, d_tag, 1'b0, 1'b0, 16'h0);
        check_eq("post_rst_first", 64'(obs_ready), 64'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
